// File: rtl/mem_bus_pkg.sv
// Shared state encoding, open-bus default and sizing helpers for the mem_bus controller.
package mem_bus_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StIdle   = 1'b0;
  localparam state_t StAccess = 1'b1;

  localparam logic [7:0] OpenBusDefault = 8'hFF;

  // Counter must reach LAT + max wait (2^WW - 1) without wrapping.
  function automatic int unsigned cnt_width(int unsigned lat, int unsigned ww);
    return $clog2(lat + (32'd1 << ww));
  endfunction

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Priority address decoder: the lowest-index region whose [lo, hi) range holds the address wins.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 16,
  parameter int unsigned IW   = idx_width(NREG)
) (
  input  logic [AW-1:0]      addr_i,
  input  logic [NREG*AW-1:0] region_lo_i,
  input  logic [NREG*AW-1:0] region_hi_i,
  output logic               hit_o,
  output logic [NREG-1:0]    match_o,
  output logic [IW-1:0]      idx_o
);

  // Scan from the top so the lowest matching index is written last; empty regions never match.
  always_comb begin
    hit_o   = 1'b0;
    match_o = '0;
    idx_o   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((addr_i >= region_lo_i[i*AW +: AW]) && (addr_i < region_hi_i[i*AW +: AW])) begin
        hit_o      = 1'b1;
        match_o    = '0;
        match_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus.sv
// CPU-side memory bus controller: region decode, per-region wait states, fixed device read
// latency, registered read return and fault reporting.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int unsigned   NREG     = 4,
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   LAT      = 2,
  parameter int unsigned   WW       = 4,
  parameter logic [DW-1:0] OPEN_BUS = DW'(OpenBusDefault)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wdata,
  input  logic               load,
  input  logic               store,
  output logic [DW-1:0]      rdata,
  output logic               rvalid,
  output logic               busy,
  output logic               fault,
  input  logic [NREG*AW-1:0] region_lo,
  input  logic [NREG*AW-1:0] region_hi,
  input  logic [NREG-1:0]    region_ro,
  input  logic [NREG*WW-1:0] region_wait,
  output logic [NREG-1:0]    dev_sel,
  output logic               dev_store,
  output logic [AW-1:0]      dev_addr,
  output logic [DW-1:0]      dev_wdata,
  input  logic [NREG*DW-1:0] dev_rdata
);

  localparam int unsigned IW = idx_width(NREG);
  localparam int unsigned CW = cnt_width(LAT, WW);
  localparam int unsigned KW = CW + 1;

  logic            hit;
  logic [NREG-1:0] match;
  logic [IW-1:0]   idx;
  logic [WW-1:0]   hit_wait;
  logic            hit_ro;

  mem_bus_decode #(
    .NREG (NREG),
    .AW   (AW),
    .IW   (IW)
  ) u_decode (
    .addr_i      (addr),
    .region_lo_i (region_lo),
    .region_hi_i (region_hi),
    .hit_o       (hit),
    .match_o     (match),
    .idx_o       (idx)
  );

  assign hit_wait = region_wait[idx*WW +: WW];
  assign hit_ro   = region_ro[idx];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_load_q, is_load_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [NREG-1:0] hit_oh_q, hit_oh_d;
  logic [NREG-1:0] dev_sel_q, dev_sel_d;
  logic            dev_store_q, dev_store_d;
  logic [AW-1:0]   dev_addr_q, dev_addr_d;
  logic [DW-1:0]   dev_wdata_q, dev_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;

  logic [KW-1:0]   k, w_end, r_end, st_busy_end;
  logic [DW-1:0]   dev_rd_mux;

  // k is the index of the upcoming edge relative to the accept edge.
  assign k           = KW'(cnt_q) + KW'(1);
  assign w_end       = KW'(wait_q) + KW'(1);
  assign r_end       = KW'(wait_q) + KW'(LAT);
  assign st_busy_end = KW'(wait_q);

  always_comb begin
    dev_rd_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      if (hit_oh_q[i]) begin
        dev_rd_mux = dev_rdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    wait_d      = wait_q;
    hit_oh_d    = hit_oh_q;
    dev_sel_d   = dev_sel_q;
    dev_store_d = dev_store_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    busy_d      = busy_q;
    fault_d     = 1'b0;

    if (state_q == StAccess) begin
      cnt_d = k[CW-1:0];
      if (k == w_end) begin
        dev_sel_d   = '0;
        dev_store_d = 1'b0;
      end
      if (is_load_q) begin
        if (k == r_end) begin
          rdata_d  = (|hit_oh_q) ? dev_rd_mux : OPEN_BUS;
          rvalid_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end else begin
        if (k == st_busy_end) begin
          busy_d = 1'b0;
        end
        if (k == w_end) begin
          state_d = StIdle;
        end
      end
    end

    // A new accept may coincide with the closing edge of the previous access and overrides it.
    if (!busy_q && (load || store)) begin
      if (load && store) begin
        fault_d = 1'b1;
      end else begin
        dev_addr_d  = addr;
        dev_wdata_d = wdata;
        if (load) begin
          state_d     = StAccess;
          cnt_d       = '0;
          is_load_d   = 1'b1;
          busy_d      = 1'b1;
          wait_d      = hit ? hit_wait : '0;
          hit_oh_d    = match;
          dev_sel_d   = match;
          dev_store_d = 1'b0;
          fault_d     = !hit;
        end else if (hit && !hit_ro) begin
          state_d     = StAccess;
          cnt_d       = '0;
          is_load_d   = 1'b0;
          busy_d      = (hit_wait != '0);
          wait_d      = hit_wait;
          hit_oh_d    = match;
          dev_sel_d   = match;
          dev_store_d = 1'b1;
        end else begin
          fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      wait_q      <= '0;
      hit_oh_q    <= '0;
      dev_sel_q   <= '0;
      dev_store_q <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      wait_q      <= wait_d;
      hit_oh_q    <= hit_oh_d;
      dev_sel_q   <= dev_sel_d;
      dev_store_q <= dev_store_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign dev_sel   = dev_sel_q;
  assign dev_store = dev_store_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: a per-cycle schedule model predicts every output, backed by a table of
// single accesses with hand-derived results and a few multi-cycle corner sequences.
module tb_mem_bus;

  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned WW   = 4;
  localparam int          MAXC = 4096;

  logic                clock = 1'b0;
  logic                reset;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       wdata;
  logic                load;
  logic                store;
  logic [DW-1:0]       rdata;
  logic                rvalid;
  logic                busy;
  logic                fault;
  logic [NREG*AW-1:0]  region_lo;
  logic [NREG*AW-1:0]  region_hi;
  logic [NREG-1:0]     region_ro;
  logic [NREG*WW-1:0]  region_wait;
  logic [NREG-1:0]     dev_sel;
  logic                dev_store;
  logic [AW-1:0]       dev_addr;
  logic [DW-1:0]       dev_wdata;
  logic [NREG*DW-1:0]  dev_rdata;

  logic [15:0] lo [4];
  logic [15:0] hi [4];
  logic [3:0]  wt [4];
  logic [3:0]  ro;

  assign region_lo   = {lo[3], lo[2], lo[1], lo[0]};
  assign region_hi   = {hi[3], hi[2], hi[1], hi[0]};
  assign region_wait = {wt[3], wt[2], wt[1], wt[0]};
  assign region_ro   = ro;

  always #5 clock = ~clock;

  mem_bus #(
    .NREG     (NREG),
    .AW       (AW),
    .DW       (DW),
    .LAT      (LAT),
    .WW       (WW),
    .OPEN_BUS (8'hFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .load        (load),
    .store       (store),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .busy        (busy),
    .fault       (fault),
    .region_lo   (region_lo),
    .region_hi   (region_hi),
    .region_ro   (region_ro),
    .region_wait (region_wait),
    .dev_sel     (dev_sel),
    .dev_store   (dev_store),
    .dev_addr    (dev_addr),
    .dev_wdata   (dev_wdata),
    .dev_rdata   (dev_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int next_free = 0;

  // Expected outputs indexed by cycle number (cycle n = the cycle following edge n).
  logic [3:0]  e_sel   [MAXC];
  logic        e_st    [MAXC];
  logic        e_busy  [MAXC];
  logic        e_rv    [MAXC];
  logic        e_fault [MAXC];
  logic [15:0] e_addr  [MAXC];
  logic [7:0]  e_wd    [MAXC];
  logic [7:0]  e_rd    [MAXC];
  int          cap     [MAXC];

  int         o_e0, o_sel_n, o_busy_n, o_rv_at, o_fault_n, o_st_n;
  logic [3:0] o_sel_or;
  logic [7:0] o_rd;

  logic [15:0] bnd [8] = '{16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000,
                           16'hDFFF, 16'hE000, 16'hFF80, 16'hFFFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_at(input int c);
    e_sel[c] = '0; e_st[c] = 1'b0; e_busy[c] = 1'b0; e_rv[c] = 1'b0; e_fault[c] = 1'b0;
    e_addr[c] = '0; e_wd[c] = '0; e_rd[c] = '0; cap[c] = -2;
  endtask

  // Called with the inputs that the DUT will sample at edge n.
  task automatic model_edge(input int n);
    int idx;
    int w;
    if (reset) begin
      for (int c = n; c < n + 40 && c < MAXC; c++) clear_at(c);
      next_free = n + 1;
      return;
    end
    if (cap[n] == -1) e_rd[n] = 8'hFF;
    else if (cap[n] >= 0) e_rd[n] = dev_rdata[cap[n]*8 +: 8];
    if (n < next_free || !(load || store)) return;
    if (load && store) begin
      e_fault[n] = 1'b1;
      next_free  = n + 1;
      return;
    end
    idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (idx < 0 && addr >= lo[i] && addr < hi[i]) idx = i;
    end
    w = (idx >= 0) ? int'(wt[idx]) : 0;
    if (load) begin
      for (int c = n; c <= n + w; c++) e_sel[c] = (idx >= 0) ? 4'(1 << idx) : 4'b0000;
      for (int c = n; c < n + LAT + w; c++) e_busy[c] = 1'b1;
      cap[n + LAT + w]  = idx;
      e_rv[n + LAT + w] = 1'b1;
      if (idx < 0) e_fault[n] = 1'b1;
      next_free = n + LAT + w + 1;
    end else if (idx >= 0 && !ro[idx]) begin
      for (int c = n; c <= n + w; c++) begin
        e_sel[c] = 4'(1 << idx); e_st[c] = 1'b1; e_addr[c] = addr; e_wd[c] = wdata;
      end
      for (int c = n; c < n + w; c++) e_busy[c] = 1'b1;
      next_free = n + w + 1;
    end else begin
      e_fault[n] = 1'b1;
      next_free  = n + 1;
    end
  endtask

  task automatic check_cycle(input int n);
    chk("dev_sel", 32'(dev_sel), 32'(e_sel[n]));
    chk("dev_store", 32'(dev_store), 32'(e_st[n]));
    chk("busy", 32'(busy), 32'(e_busy[n]));
    chk("rvalid", 32'(rvalid), 32'(e_rv[n]));
    chk("fault", 32'(fault), 32'(e_fault[n]));
    if (e_rv[n]) chk("rdata", 32'(rdata), 32'(e_rd[n]));
    if (e_st[n]) begin
      chk("dev_addr", 32'(dev_addr), 32'(e_addr[n]));
      chk("dev_wdata", 32'(dev_wdata), 32'(e_wd[n]));
    end
  endtask

  task automatic obs_start();
    o_e0 = cyc; o_sel_n = 0; o_busy_n = 0; o_rv_at = -1; o_fault_n = 0; o_st_n = 0;
    o_sel_or = '0; o_rd = '0;
  endtask

  task automatic observe();
    if (dev_sel != '0) begin o_sel_n++; o_sel_or |= dev_sel; end
    if (busy) o_busy_n++;
    if (rvalid) begin o_rv_at = cyc - o_e0; o_rd = rdata; end
    if (fault) o_fault_n++;
    if (dev_store) o_st_n++;
  endtask

  task automatic cycle();
    model_edge(cyc);
    @(posedge clock);
    @(negedge clock);
    check_cycle(cyc);
    observe();
    cyc++;
  endtask

  task automatic set_common();
    lo[0] = 16'h0000; hi[0] = 16'h8000; wt[0] = 4'd0;
    lo[1] = 16'hC000; hi[1] = 16'hE000; wt[1] = 4'd0;
    lo[2] = 16'hFF80; hi[2] = 16'hFFFF; wt[2] = 4'd0;
    lo[3] = 16'hFF00; hi[3] = 16'hFF80; wt[3] = 4'd3;
    ro = 4'b0001;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: pick_addr = r;
      1: pick_addr = {1'b0, r[14:0]};
      2: pick_addr = {3'b110, r[12:0]};
      3: pick_addr = {8'hFF, r[7:0]};
      default: pick_addr = bnd[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic random_seg(input int ncyc);
    int r;
    for (int i = 0; i < ncyc; i++) begin
      r         = $urandom_range(0, 9);
      load      = (r <= 3) || (r == 7);
      store     = (r >= 4) && (r <= 7);
      addr      = pick_addr();
      wdata     = 8'($urandom);
      dev_rdata = $urandom;
      reset     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    load = 1'b0; store = 1'b0; reset = 1'b0;
    repeat (25) cycle();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        ld;
    logic        st;
    logic [7:0]  wd;
    logic [3:0]  sel;
    int          sel_n;
    int          busy_n;
    int          rv_at;
    logic [7:0]  rd;
    int          fault_n;
    int          st_n;
  } vec_t;

  vec_t vt [13];

  initial begin
    for (int c = 0; c < MAXC; c++) clear_at(c);
    set_common();
    reset = 1'b1; load = 1'b0; store = 1'b0; addr = '0; wdata = '0;
    dev_rdata = {8'hC3, 8'h5E, 8'hA5, 8'h3C};

    // addr, load, store, wdata | sel mask, sel cycles, busy cycles, rvalid at, rdata, faults, strobes
    vt[0]  = '{16'h0150, 1'b1, 1'b0, 8'h00, 4'b0001, 1, 2, 2, 8'h3C, 0, 0};
    vt[1]  = '{16'hC000, 1'b0, 1'b1, 8'h5A, 4'b0010, 1, 0, -1, 8'h00, 0, 1};
    vt[2]  = '{16'h2000, 1'b0, 1'b1, 8'h77, 4'b0000, 0, 0, -1, 8'h00, 1, 0};
    vt[3]  = '{16'hFF01, 1'b1, 1'b0, 8'h00, 4'b1000, 4, 5, 5, 8'hC3, 0, 0};
    vt[4]  = '{16'hA000, 1'b1, 1'b0, 8'h00, 4'b0000, 0, 2, 2, 8'hFF, 1, 0};
    vt[5]  = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 4'b0000, 0, 2, 2, 8'hFF, 1, 0};
    vt[6]  = '{16'hDFFF, 1'b1, 1'b0, 8'h00, 4'b0010, 1, 2, 2, 8'hA5, 0, 0};
    vt[7]  = '{16'hC000, 1'b1, 1'b1, 8'h00, 4'b0000, 0, 0, -1, 8'h00, 1, 0};
    vt[8]  = '{16'hFF80, 1'b1, 1'b0, 8'h00, 4'b0100, 1, 2, 2, 8'h5E, 0, 0};
    vt[9]  = '{16'hFF7F, 1'b0, 1'b1, 8'h99, 4'b1000, 4, 3, -1, 8'h00, 0, 4};
    vt[10] = '{16'h8000, 1'b1, 1'b0, 8'h00, 4'b0000, 0, 2, 2, 8'hFF, 1, 0};
    vt[11] = '{16'h7FFF, 1'b1, 1'b0, 8'h00, 4'b0001, 1, 2, 2, 8'h3C, 0, 0};
    vt[12] = '{16'hE000, 1'b0, 1'b1, 8'h44, 4'b0000, 0, 0, -1, 8'h00, 1, 0};

    repeat (2) cycle();
    chk("reset.rdata", 32'(rdata), 32'h0);
    chk("reset.dev_addr", 32'(dev_addr), 32'h0);
    chk("reset.dev_wdata", 32'(dev_wdata), 32'h0);
    chk("reset.dev_sel", 32'(dev_sel), 32'h0);
    reset = 1'b0;
    cycle();

    for (int v = 0; v < 13; v++) begin
      addr = vt[v].addr; load = vt[v].ld; store = vt[v].st; wdata = vt[v].wd;
      obs_start();
      cycle();
      load = 1'b0; store = 1'b0;
      repeat (12) cycle();
      chk($sformatf("v%0d.sel_mask", v), 32'(o_sel_or), 32'(vt[v].sel));
      chk($sformatf("v%0d.sel_cycles", v), o_sel_n, vt[v].sel_n);
      chk($sformatf("v%0d.busy_cycles", v), o_busy_n, vt[v].busy_n);
      chk($sformatf("v%0d.rvalid_at", v), o_rv_at, vt[v].rv_at);
      if (vt[v].rv_at >= 0) chk($sformatf("v%0d.rdata", v), 32'(o_rd), 32'(vt[v].rd));
      chk($sformatf("v%0d.faults", v), o_fault_n, vt[v].fault_n);
      chk($sformatf("v%0d.strobes", v), o_st_n, vt[v].st_n);
    end

    // Back-to-back zero-wait stores.
    store = 1'b1; addr = 16'hC000; wdata = 8'h5A;
    cycle();
    chk("b2b.first_store", 32'(dev_store), 32'h1);
    chk("b2b.first_addr", 32'(dev_addr), 32'hC000);
    chk("b2b.first_wdata", 32'(dev_wdata), 32'h5A);
    addr = 16'hC001; wdata = 8'h11;
    cycle();
    chk("b2b.second_store", 32'(dev_store), 32'h1);
    chk("b2b.second_sel", 32'(dev_sel), 32'h2);
    chk("b2b.second_addr", 32'(dev_addr), 32'hC001);
    chk("b2b.second_wdata", 32'(dev_wdata), 32'h11);
    store = 1'b0;
    cycle();
    chk("b2b.done", 32'(dev_store), 32'h0);
    repeat (3) cycle();

    // Load held through busy is re-accepted only at E6.
    load = 1'b1; addr = 16'hFF01;
    obs_start();
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k == 5) begin
        chk("held.sel_at5", 32'(dev_sel), 32'h0);
        chk("held.rvalid_at5", 32'(rvalid), 32'h1);
      end
      if (k == 6) begin
        chk("held.sel_at6", 32'(dev_sel), 32'h8);
        chk("held.busy_at6", 32'(busy), 32'h1);
      end
    end
    load = 1'b0;
    repeat (10) cycle();

    // Overlapping regions: lowest index wins.
    lo[2] = 16'hC000; hi[2] = 16'hE000;
    load = 1'b1; addr = 16'hC800;
    obs_start();
    cycle();
    load = 1'b0;
    repeat (6) cycle();
    chk("overlap.sel", 32'(o_sel_or), 32'h2);
    chk("overlap.rdata", 32'(o_rd), 32'hA5);
    set_common();

    // Reset at E2 of a waited access aborts it with no late rvalid.
    load = 1'b1; addr = 16'hFF01;
    cycle();
    load = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.dev_sel", 32'(dev_sel), 32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'h0);
    chk("rst.rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    obs_start();
    repeat (8) cycle();
    chk("rst.no_late_rvalid", o_rv_at, -1);
    load = 1'b1; addr = 16'h0150;
    obs_start();
    cycle();
    load = 1'b0;
    repeat (5) cycle();
    chk("rst.after_rvalid_at", o_rv_at, 2);
    chk("rst.after_rdata", 32'(o_rd), 32'h3C);

    random_seg(400);
    for (int i = 0; i < 4; i++) wt[i] = 4'($urandom_range(0, 15));
    ro = 4'($urandom);
    random_seg(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus.md
Name: mem_bus

Overview:
- Parametrised CPU-side memory bus controller.
- Replaces the hand-written address latch chain and read-data mux in the top level with a generic block.
- Decodes each CPU load/store against NREG programmable address regions and drives one-hot device selects.
- Inserts per-region wait states, applies a fixed device read latency, and returns registered read data with a valid pulse. Unmapped reads return open-bus data.

Parameters:
- NREG, 4, number of decoded regions/devices
- AW, 16, address width
- DW, 8, data width
- LAT, 2, device read latency in clocks from select to data (synchronous RAM/ROM), >=1
- WW, 4, width of per-region wait-state field
- OPEN_BUS, 8'hFF, read data returned for unmapped addresses

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- addr  in  AW  CPU address
- wdata  in  DW  CPU store data
- load  in  1  CPU read request
- store  in  1  CPU write request
- rdata  out  DW  registered read data
- rvalid  out  1  one-cycle pulse, rdata valid
- busy  out  1  access in progress; requests ignored while high
- fault  out  1  one-cycle pulse: unmapped access, write to read-only region, or load&store together
- region_lo  in  NREG*AW  region i inclusive base, slice [i*AW +: AW]
- region_hi  in  NREG*AW  region i exclusive limit
- region_ro  in  NREG  region i read-only
- region_wait  in  NREG*WW  region i wait states
- dev_sel  out  NREG  one-hot device select
- dev_store  out  1  device write strobe, qualified by dev_sel
- dev_addr  out  AW  registered device address
- dev_wdata  out  DW  registered device write data
- dev_rdata  in  NREG*DW  per-device read data, slice [i*DW +: DW]

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0. Reset mid-access aborts it, and no late rvalid or dev_store is produced.

Decode:
- Region i hits when region_lo_i <= addr < region_hi_i (unsigned).
- Lowest index wins on overlap. Empty region (lo >= hi) never hits.

States:
- IDLE
  - Sample request each cycle; accept edge = E0.
  - load xor store: access accepted.
  - load and store together: fault pulse, nothing accepted, stay IDLE.
  - Neither: no action.
- ACCESS
  - Counter counts clocks since E0.
  - dev_sel held from E0 until E(W+1), where W = wait of the hit region.
  - dev_addr and dev_wdata are registered at E0 and held until return to IDLE.
- Read:
  - rdata captured from dev_rdata[hit] at edge E(LAT+W).
  - rvalid high for the cycle after that edge.
  - busy high from E0 to E(LAT+W); busy drops in the same cycle rvalid rises.
  - Next accept at E(LAT+W+1) at the earliest.
- Store, mapped and writable:
  - dev_store high together with dev_sel for W+1 cycles; busy high for W cycles.
  - With W=0, back-to-back stores run every cycle.
- Store to a read-only region or unmapped address:
  - No dev_sel, no dev_store.
  - fault pulses the cycle after E0; busy stays low.
- Unmapped read:
  - No dev_sel.
  - rdata = OPEN_BUS, rvalid after E(LAT), wait 0.
  - fault pulses the cycle after E0.
- Requests while busy are ignored, not queued. A request still held when busy drops is accepted at the next edge.
- Region configuration inputs are static during an access; changes take effect at the next accept.
- The counter is wide enough for LAT + 2^WW - 1 with no wrap.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, ACCESS)
  - OPEN_BUS default
  - counter-width constant function clog2(LAT + 2^WW)
- Sub-module mem_bus_decode: combinational priority match of addr against the region ports. Outputs hit, one-hot match and index. Reused by the debug address decoder.

Test Plan:
Common setup: NREG=4, LAT=2, regions:
- r0 0000-8000, ro, wait 0
- r1 C000-E000, wait 0
- r2 FF80-FFFF, wait 0
- r3 FF00-FF80, wait 3

1. Load 0x0150 with dev_rdata r0=0x3C -> dev_sel=0001 for 1 cycle, busy 2 cycles, rvalid with rdata 0x3C after E2, fault 0.
2. Store 0x5A to 0xC000, then 0x11 to 0xC001 on consecutive cycles -> dev_store pulses twice with sel 0010, dev_addr C000/C001, dev_wdata 5A/11, no rvalid. Store to 0x2000 -> no dev_store, fault pulse.
3. Load 0xFF01 -> dev_sel=1000 for 4 cycles, busy until E5, rvalid after E5. A load held during busy is accepted only at E6.
4. Boundaries:
   - Load 0xA000 -> no sel, rvalid after E2 with 0xFF, fault pulse.
   - Load 0xFFFF -> unmapped, 0xFF.
   - Load 0xDFFF -> r1.
   - Overlap r1 and r2 both set to C000-E000 -> r1 selected.
5. load=store=1 at 0xC000 -> fault pulse, no sel/strobe, busy stays 0.
6. reset asserted at E2 of the 0xFF01 access -> next cycle busy, dev_sel, rvalid and rdata are all 0; no rvalid appears later. A new load after reset completes normally.
